// File: rtl/finger_pkg.sv
// Shared types and helpers for the button debounce scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: event record {btn index, press bit}, scan FSM state enum,
// and the tick-period computation used by the prescaler.
package finger_pkg;

   // Wide enough for the largest supported bank (16 buttons).
   localparam int BTN_IDX_W = 4;

   typedef struct packed {
      logic [BTN_IDX_W-1:0] btn;
      logic                 press;
   } evt_t;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } scan_st_t;

   // Clock cycles per sample tick.
   function automatic int tick_cyc(input int clk_hz, input int tick_us);
      return (clk_hz / 1_000_000) * tick_us;
   endfunction

endpackage

// File: rtl/btn_evt_fifo.sv
// Synchronous event FIFO with a registered head word.
// Latency: a push into an empty FIFO is visible at the head one cycle later (no bypass).
// Backpressure: head holds while not popped; a push when full is accepted only alongside a pop.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   i_push, i_din     write request and data
//   i_pop             read request (ignored when empty)
//   o_head            registered head word
//   o_full, o_empty   occupancy flags
module btn_evt_fifo #(
   parameter int DEPTH = 4,
   parameter int DW    = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_push,
   input  logic [DW-1:0] i_din,
   input  logic          i_pop,
   output logic [DW-1:0] o_head,
   output logic          o_full,
   output logic          o_empty
);

   localparam int AW = $clog2(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("btn_evt_fifo: DEPTH must be a power of two >= 2");
   end

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [AW:0]   r_cnt;
   logic [DW-1:0] r_head;

   logic          w_do_pop;
   logic          w_do_push;
   logic [AW-1:0] w_rd_nxt;

   assign o_full   = (r_cnt == (AW+1)'(DEPTH));
   assign o_empty  = (r_cnt == '0);
   assign o_head   = r_head;
   assign w_rd_nxt = r_rd + AW'(1);

   assign w_do_pop  = i_pop && !o_empty;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr] <= i_din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr   <= '0;
         r_rd   <= '0;
         r_cnt  <= '0;
         r_head <= '0;
      end else begin
         if (w_do_push) begin
            r_wr <= r_wr + AW'(1);
         end
         if (w_do_pop) begin
            r_rd <= w_rd_nxt;
         end
         r_cnt <= r_cnt + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);

         // Head register tracks mem[r_rd]; the only case needing i_din
         // directly is when the slot behind the head is the one being written.
         if (w_do_pop) begin
            if (r_cnt > (AW+1)'(1)) begin
               r_head <= r_mem[w_rd_nxt];
            end else if (w_do_push) begin
               r_head <= i_din;
            end
         end else if (o_empty && w_do_push) begin
            r_head <= i_din;
         end
      end
   end

endmodule

// File: rtl/btn_scan_sched.sv
// Shared-tick debounce scheduler: one prescaler, round-robin scan FSM, per-button
// sample histories, debounced levels and a press/release event queue.
// Latency: button i sampled T+1+i after tick T; event visible T+2+i (empty queue).
// Backpressure: evt_valid/evt_ready; events arriving at a full queue are dropped
//   and latch evt_overflow until ovf_clr.
//
// Config macro: BTN_RELEASE_EVT_EN -- when defined, release events are queued as
//   well as presses; when undefined only presses are queued and evt_press is 1.
//
// Ports:
//   clk, rst_n     clock, async active-low reset
//   btn_raw        raw asynchronous pushbuttons
//   btn_level      debounced levels
//   evt_valid/evt_ready/evt_btn/evt_press   head of event queue
//   evt_overflow   sticky drop flag, ovf_clr clears it
module btn_scan_sched
   import finger_pkg::*;
#(
   parameter int N_BTN      = 4,
   parameter int CLK_HZ     = 100_000_000,
   parameter int TICK_US    = 1000,
   parameter int HIST       = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_BTN-1:0]         btn_raw,
   output logic [N_BTN-1:0]         btn_level,
   output logic                     evt_valid,
   input  logic                     evt_ready,
   output logic [$clog2(N_BTN)-1:0] evt_btn,
   output logic                     evt_press,
   output logic                     evt_overflow,
   input  logic                     ovf_clr
);

   localparam int IW       = $clog2(N_BTN);
   localparam int TICK_CYC = tick_cyc(CLK_HZ, TICK_US);
   localparam int PW       = $clog2(TICK_CYC);

`ifdef BTN_RELEASE_EVT_EN
   localparam bit REL_EN = 1'b1;
`else
   localparam bit REL_EN = 1'b0;
`endif

   // A full scan must finish before the next tick arrives.
   if (TICK_CYC < N_BTN + 2) begin : g_bad_tick
      $error("btn_scan_sched: TICK_CYC must be >= N_BTN+2");
   end
   if (N_BTN < 2 || N_BTN > 16) begin : g_bad_nbtn
      $error("btn_scan_sched: N_BTN must be 2..16");
   end
   if (HIST < 2) begin : g_bad_hist
      $error("btn_scan_sched: HIST must be >= 2");
   end

   logic [N_BTN-1:0] r_sync1;
   logic [N_BTN-1:0] r_sync2;
   logic [PW-1:0]    r_presc;
   logic [HIST-1:0]  r_hist [N_BTN];
   logic [N_BTN-1:0] r_level;
   logic             r_ovf;
   scan_st_t         r_state;
   logic [IW-1:0]    r_idx;

   scan_st_t         w_state_nxt;
   logic [IW-1:0]    w_idx_nxt;
   logic             w_scan;
   logic             w_tick;
   logic [HIST-1:0]  w_hist_nxt;
   logic             w_rise;
   logic             w_fall;
   logic             w_push;
   logic             w_pop;
   logic             w_drop;
   evt_t             w_push_evt;
   evt_t             w_head;
   logic             w_full;
   logic             w_empty;
   logic             w_unused_head;

   // ---------------- synchronizer (every cycle) ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= btn_raw;
         r_sync2 <= r_sync1;
      end
   end

   // ---------------- prescaler ----------------
   assign w_tick = (r_presc == PW'(TICK_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc <= '0;
      end else if (w_tick) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + PW'(1);
      end
   end

   // ---------------- scan FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_scan      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_tick) begin
               w_state_nxt = SCAN;
               w_idx_nxt   = '0;
            end
         end
         SCAN: begin
            w_scan = 1'b1;
            if (r_idx == IW'(N_BTN - 1)) begin
               w_state_nxt = IDLE;
            end else begin
               w_idx_nxt = r_idx + IW'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // ---------------- history / level ----------------
   // Level decisions look at the history including this cycle's sample.
   assign w_hist_nxt = {r_hist[r_idx][HIST-2:0], r_sync2[r_idx]};
   assign w_rise     = w_scan && (w_hist_nxt == '1) && !r_level[r_idx];
   assign w_fall     = w_scan && (w_hist_nxt == '0) &&  r_level[r_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_BTN; i++) begin
            r_hist[i] <= '0;
         end
         r_level <= '0;
      end else if (w_scan) begin
         r_hist[r_idx] <= w_hist_nxt;
         if (w_rise) begin
            r_level[r_idx] <= 1'b1;
         end else if (w_fall) begin
            r_level[r_idx] <= 1'b0;
         end
      end
   end

   assign btn_level = r_level;

   // ---------------- event queue ----------------
   assign w_push           = w_rise || (REL_EN && w_fall);
   assign w_push_evt.btn   = BTN_IDX_W'(r_idx);
   assign w_push_evt.press = w_rise;
   assign w_pop            = evt_valid && evt_ready;
   assign w_drop           = w_push && w_full && !w_pop;

   btn_evt_fifo #(
      .DEPTH (FIFO_DEPTH),
      .DW    ($bits(evt_t))
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_din   (w_push_evt),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign evt_valid = !w_empty;
   assign evt_btn   = w_head.btn[IW-1:0];

`ifdef BTN_RELEASE_EVT_EN
   assign evt_press = w_head.press;
`else
   assign evt_press = 1'b1;
`endif

   // Upper index bits (and press, when releases are not queued) are don't-care.
   assign w_unused_head = ^w_head;

   // A drop in the same cycle as a clear wins, so no loss goes unreported.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (w_drop) begin
         r_ovf <= 1'b1;
      end else if (ovf_clr) begin
         r_ovf <= 1'b0;
      end
   end

   assign evt_overflow = r_ovf;

endmodule

// File: tb/tb_btn_scan_sched.sv
// Directed bench for btn_scan_sched with TICK_CYC = 10, N_BTN = 4, HIST = 8, depth 4.
// Cycle k counts clock edges since reset release; ticks fall in cycles k%10==9,
// button i is sampled in cycles k%10==i, its level changes from cycle k+1.
module tb_btn_scan_sched;

`ifdef BTN_RELEASE_EVT_EN
   localparam bit REL = 1'b1;
`else
   localparam bit REL = 1'b0;
`endif

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b1;
   logic [3:0] btn_raw   = '0;
   logic       evt_ready = 1'b0;
   logic       ovf_clr   = 1'b0;
   logic [3:0] btn_level;
   logic       evt_valid;
   logic [1:0] evt_btn;
   logic       evt_press;
   logic       evt_overflow;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   logic [2:0] evq [$];

   always #5 clk = ~clk;

   btn_scan_sched #(
      .N_BTN      (4),
      .CLK_HZ     (1_000_000),
      .TICK_US    (10),
      .HIST       (8),
      .FIFO_DEPTH (4)
   ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .btn_raw      (btn_raw),
      .btn_level    (btn_level),
      .evt_valid    (evt_valid),
      .evt_ready    (evt_ready),
      .evt_btn      (evt_btn),
      .evt_press    (evt_press),
      .evt_overflow (evt_overflow),
      .ovf_clr      (ovf_clr)
   );

   // Record every accepted event as {btn, press}.
   always @(negedge clk) begin
      if (rst_n && evt_valid && evt_ready) evq.push_back({evt_btn, evt_press});
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout, expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic go(input int k);
      while (cyc < k) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      #1;
      chk({tag, "_rst_level"}, btn_level, 4'h0);
      chk({tag, "_rst_valid"}, evt_valid, 1'b0);
      chk({tag, "_rst_btn"},   evt_btn, 2'd0);
      chk({tag, "_rst_press"}, evt_press, REL ? 1'b0 : 1'b1);
      chk({tag, "_rst_ovf"},   evt_overflow, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc   = 0;
      evq.delete();
   endtask

   initial begin
      logic bad;
      #2;

      // ---------- clean press on button 2 ----------
      do_reset("s0");
      evt_ready = 1'b1;
      go(15); btn_raw = 4'b0100;
      go(92);
      chk("clean_lvl_pre",   btn_level, 4'b0000);
      chk("clean_vld_pre",   evt_valid, 1'b0);
      go(93);
      chk("clean_lvl",       btn_level, 4'b0100);
      chk("clean_vld",       evt_valid, 1'b1);
      chk("clean_btn",       evt_btn, 2'd2);
      chk("clean_press",     evt_press, 1'b1);
      go(94);
      chk("clean_vld_pop",   evt_valid, 1'b0);
      go(115);
      chk("clean_nevt",      evq.size(), 1);
      chk("clean_evt0",      evq[0], 3'b101);
      btn_raw = 4'b0000;
      go(195);
      chk("clean_rel_lvl",   btn_level, 4'b0000);
      chk("clean_rel_nevt",  evq.size(), REL ? 2 : 1);

      // ---------- bounce on button 0 ----------
      btn_raw = 4'b0000;
      do_reset("s1");
      evt_ready = 1'b1;
      bad = 1'b0;
      for (int k = 15; k <= 160; k++) begin
         go(k);
         if (k <= 78 && ((k - 15) % 7) == 0) btn_raw[0] = ~btn_raw[0];
         if (k == 85) btn_raw[0] = 1'b1;
         if (btn_level != 4'b0000) bad = 1'b1;
      end
      chk("bounce_no_change", bad, 1'b0);
      go(161);
      chk("bounce_lvl",  btn_level, 4'b0001);
      chk("bounce_vld",  evt_valid, 1'b1);
      go(170);
      chk("bounce_nevt", evq.size(), 1);
      chk("bounce_evt0", evq[0], 3'b001);

      // ---------- simultaneous buttons 1 and 3 ----------
      btn_raw = 4'b0000;
      do_reset("s2");
      evt_ready = 1'b1;
      go(15); btn_raw = 4'b1010;
      go(91); chk("sim_lvl_a", btn_level, 4'b0000);
      go(92); chk("sim_lvl_b", btn_level, 4'b0010);
      go(93); chk("sim_vld_gap", evt_valid, 1'b0);
      go(94); chk("sim_lvl_c", btn_level, 4'b1010);
      go(100);
      chk("sim_nevt", evq.size(), 2);
      chk("sim_evt0", evq[0], 3'b011);
      chk("sim_evt1", evq[1], 3'b111);

      // ---------- backpressure / overflow ----------
      btn_raw = 4'b0000;
      do_reset("s3");
      evt_ready = 1'b0;
      go(15); btn_raw = 4'b1111;
      go(100);
      chk("bp_lvl",   btn_level, 4'b1111);
      chk("bp_vld",   evt_valid, 1'b1);
      chk("bp_btn",   evt_btn, 2'd0);
      chk("bp_cnt",   u_dut.u_fifo.r_cnt, 3'd4);
      go(115); btn_raw = 4'b0000;
      go(200);
      chk("bp_rel_lvl", btn_level, 4'b0000);
      chk("bp_ovf",     evt_overflow, REL);
      evt_ready = 1'b1;
      go(210);
      chk("bp_drain_vld", evt_valid, 1'b0);
      chk("bp_nevt", evq.size(), 4);
      chk("bp_evt0", evq[0], 3'b001);
      chk("bp_evt1", evq[1], 3'b011);
      chk("bp_evt2", evq[2], 3'b101);
      chk("bp_evt3", evq[3], 3'b111);
      ovf_clr = 1'b1;
      go(211);
      ovf_clr = 1'b0;
      chk("bp_ovf_clr", evt_overflow, 1'b0);

      // ---------- reset mid-scan (idx 2, two events queued) ----------
      btn_raw = 4'b0000;
      do_reset("s4");
      evt_ready = 1'b0;
      go(15); btn_raw = 4'b0011;
      go(102);
      chk("rms_cnt_pre", u_dut.u_fifo.r_cnt, 3'd2);
      chk("rms_vld_pre", evt_valid, 1'b1);
      do_reset("rms");
      go(80); chk("rms_lvl_80", btn_level, 4'b0000);
      go(81); chk("rms_lvl_81", btn_level, 4'b0001);
      chk("rms_vld_81", evt_valid, 1'b1);
      go(82); chk("rms_lvl_82", btn_level, 4'b0011);

      // ---------- head holds under backpressure ----------
      btn_raw = 4'b0000;
      do_reset("s5");
      evt_ready = 1'b0;
      go(15); btn_raw = 4'b0001;
      go(25); btn_raw = 4'b0101;
      go(100); chk("hold_cnt1", u_dut.u_fifo.r_cnt, 3'd1);
      bad = 1'b0;
      for (int k = 91; k <= 111; k++) begin
         go(k);
         if (!(evt_valid === 1'b1 && evt_btn === 2'd0 && evt_press === 1'b1)) bad = 1'b1;
         if (k == 104) chk("hold_cnt2", u_dut.u_fifo.r_cnt, 3'd2);
      end
      chk("hold_stable", bad, 1'b0);
      evt_ready = 1'b1;
      go(115);
      chk("hold_nevt", evq.size(), 2);
      chk("hold_evt0", evq[0], 3'b001);
      chk("hold_evt1", evq[1], 3'b101);
      chk("hold_vld_end", evt_valid, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/btn_scan_sched.md
# btn_scan_sched

Shared debounce scheduler for the game's button bank. A single millisecond tick generator replaces a derived per-button clock. Each tick, a scan state machine visits every button in round-robin order and shifts one synchronized sample into that button's history. Debounced levels and a press/release event queue (valid/ready) feed the game-logic and scoring blocks. It sits between the raw board pushbuttons and the note-judgement logic.

## Interface
Parameters:
- N_BTN, 4, number of buttons (2..16)
- CLK_HZ, 100_000_000, system clock frequency
- TICK_US, 1000, sample period in microseconds
- HIST, 8, consecutive equal samples required to change level
- FIFO_DEPTH, 4, event queue depth (power of two)

Ports:
- clk  in  1  system clock; all logic on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- btn_raw  in  N_BTN  raw asynchronous button inputs
- btn_level  out  N_BTN  debounced levels
- evt_valid  out  1  head event present
- evt_ready  in  1  consumer accepts head event
- evt_btn  out  $clog2(N_BTN)  button index of head event
- evt_press  out  1  1 = press, 0 = release
- evt_overflow  out  1  sticky flag: an event was dropped
- ovf_clr  in  1  clears evt_overflow

## Operation
- Reset:
  - prescaler = 0, all histories = 0, btn_level = 0, FIFO empty, evt_valid = 0, evt_overflow = 0, FSM in IDLE.
  - rst_n asserted mid-scan aborts the scan immediately; queued events are discarded.
- Synchronizer: each btn_raw bit goes through a 2-flop synchronizer that runs every cycle.
- Prescaler:
  - TICK_CYC = CLK_HZ/1_000_000*TICK_US.
  - The prescaler counts 0..TICK_CYC-1 and pulses tick for one cycle at the terminal count.
  - Elaboration fails if TICK_CYC < N_BTN+2.
- FSM states:
  - IDLE: on tick, go to SCAN with idx = 0.
  - SCAN: one button per cycle. hist[idx] <= {hist[idx][HIST-2:0], sync[idx]}. If idx == N_BTN-1, go to IDLE; otherwise idx++.
- Level update, evaluated on the new history:
  - All ones and level = 0: level <= 1; push press event {idx, 1}.
  - All zeros and level = 1: level <= 0; push release event {idx, 0}.
  - Otherwise no change.
- Event order: events are queued in scan order, so within a tick the lower index goes first.
- FIFO handshake:
  - A pop occurs when evt_valid && evt_ready.
  - A push is accepted if not full, or if full with a pop in the same cycle.
  - A rejected push is dropped and sets evt_overflow.
  - Head outputs hold stable while evt_valid && !evt_ready.
  - Empty with a simultaneous push: the event appears next cycle; there is no bypass.
- Overflow flag: ovf_clr clears it. If ovf_clr and a new drop occur in the same cycle, the flag stays set.

## Timing
- Tick pulse at cycle T: button i is scanned in cycle T+1+i.
- btn_level[i] and FIFO write take effect at the edge ending T+1+i.
- evt_valid rises in cycle T+2+i when the FIFO was empty.
- Debounce latency: HIST ticks of stable input, plus up to one tick of phase, plus 2 sync cycles, plus N_BTN cycles.
- A single-tick glitch of either polarity never changes the level.
- Throughput: one pop per cycle. Pushes are limited to at most N_BTN per tick.

## Configuration
- BTN_RELEASE_EVT_EN defined: both press and release events are queued, as described above.
- Undefined: only press events are queued. Release transitions still update btn_level. evt_press is tied to 1.

## Structure
- Shared package finger_pkg holds:
  - the event struct {btn index, press bit}
  - the FSM state enum (IDLE, SCAN)
  - the TICK_CYC computation function
- Sub-module btn_evt_fifo: synchronous FIFO parameterized by depth and data width. It provides full/empty, push/pop, and registered head outputs.
- Top level contains the prescaler, synchronizers, history registers, FSM and overflow logic.

## Test plan
All scenarios use CLK_HZ = 1_000_000, TICK_US = 10 (TICK_CYC = 10), N_BTN = 4, HIST = 8, FIFO_DEPTH = 4.
- Clean press: btn_raw[2] = 1 held 100 cycles, evt_ready = 1.
  - btn_level[2] rises after the 8th sampling tick.
  - Exactly one event {2, press}; no other events.
- Bounce: btn_raw[0] toggles every 7 cycles for 70 cycles, then holds 1.
  - No level change during the toggling.
  - One press event, once 8 consecutive ones have been sampled.
- Simultaneous: btn_raw[3] and btn_raw[1] rise in the same cycle.
  - Both levels rise in the same tick.
  - Events are emitted in order {1, press} then {3, press}.
- Backpressure/overflow: evt_ready = 0; press then release all 4 buttons (8 events).
  - The first 4 events are kept in order.
  - evt_overflow = 1 with the macro defined; it stays 0 without the macro (4 events only).
  - Raising evt_ready drains 4 events; ovf_clr clears the flag.
- Reset mid-scan: assert rst_n = 0 during SCAN with idx = 2 and 2 events queued.
  - All outputs are 0 immediately.
  - After release, the input held at 1 re-debounces from empty history (8 ticks).
- Hold-stable: evt_valid = 1 and evt_ready = 0 for 20 cycles while a new event is pushed.
  - evt_btn and evt_press stay unchanged.
  - The FIFO count increments.
